bram_access_ctrl: RTL
=====================

# bram_access_ctrl

Client-side access controller for the dual-port BRAM: turns a valid/ready request stream into per-cycle BRAM port strobes and returns read data over a valid/ready response channel. It absorbs the BRAM's one-cycle read latency, holds read data under response backpressure, and can zero-fill the memory after reset. One instance drives one BRAM port pair (write port A / read port A, or likewise for B) and sits between a client engine and `dual_port_bram`.

## Interface
Parameters:
- DATA_WIDTH, 8, BRAM word width
- ADDR_WIDTH, 4, BRAM address width; depth = 2^ADDR_WIDTH

Ports:
- i_CLK  in  1  clock, all logic on rising edge
- i_RST_N  in  1  reset, asynchronous assert, active-low; one clock, asynchronous active-low reset
- i_REQ_VALID  in  1  request valid
- o_REQ_READY  out  1  request accepted when valid & ready
- i_REQ_WRITE  in  1  1 = write, 0 = read
- i_REQ_ADDRESS  in  ADDR_WIDTH  request address
- i_REQ_DATA  in  DATA_WIDTH  write data
- o_RSP_VALID  out  1  read response valid
- i_RSP_READY  in  1  response consumed when valid & ready
- o_RSP_DATA  out  DATA_WIDTH  read data
- o_MEM_WRITE_ENABLE  out  1  to BRAM i_WRITE_ENABLE_x
- o_MEM_WRITE_ADDRESS  out  ADDR_WIDTH  to BRAM i_WRITE_ADDRESS_x
- o_MEM_WRITE_DATA  out  DATA_WIDTH  to BRAM i_WRITE_DATA_x
- o_MEM_READ_ENABLE  out  1  to BRAM i_READ_ENABLE_x
- o_MEM_READ_ADDRESS  out  ADDR_WIDTH  to BRAM i_READ_ADDRESS_x
- i_MEM_READ_DATA  in  DATA_WIDTH  from BRAM o_READ_DATA_x (registered, valid cycle after read enable)
- o_INIT_DONE  out  1  controller in RUN state

## Operation
- States: CLEAR (only with macro), RUN. Reset enters CLEAR if compiled in, else RUN.
- CLEAR: counter clr_addr from 0; each cycle drive write enable=1, address=clr_addr, data=0; clr_addr increments; after address 2^ADDR_WIDTH-1 written, go to RUN. o_REQ_READY=0, read enable=0.
- RUN: memory strobes are combinational from the accept: write accept -> o_MEM_WRITE_ENABLE=1, address/data from request; read accept -> o_MEM_READ_ENABLE=1, read address from request. No accept -> both enables 0; address/data outputs then don't-care.
- Occupancy = rd_inflight (1-bit, set on read accept, cleared next cycle) + resp buffer count (0..2).
- o_REQ_READY = RUN & (i_REQ_WRITE | occupancy < 2). Ready depends on i_REQ_WRITE; writes never stall in RUN.
- Response buffer: 2-entry FIFO. o_RSP_VALID = count>0 | rd_inflight. o_RSP_DATA = FIFO head if count>0, else i_MEM_READ_DATA (bypass).
- When rd_inflight: i_MEM_READ_DATA pushed into FIFO unless it is consumed by bypass in the same cycle. Push and pop in same cycle with count>0 keeps count.
- Responses returned strictly in request order. Writes produce no response.
- Read of an address written in an earlier cycle returns the new data; one request per cycle excludes same-cycle conflicts.

## Timing
- Reset values: o_REQ_READY=0, o_RSP_VALID=0, o_RSP_DATA=0, all o_MEM_* =0, o_INIT_DONE=0 (macro) / 1 (no macro), FIFO empty, rd_inflight=0, clr_addr=0.
- Read latency: accepted in cycle N -> o_RSP_VALID=1 with data in cycle N+1.
- Throughput: one read per cycle sustained while i_RSP_READY=1.
- Backpressure: with i_RSP_READY=0, at most 2 reads accepted; third read stalls until a pop.
- Reset mid-operation: in-flight read, buffered responses and CLEAR progress discarded; CLEAR restarts at address 0.
- CLEAR lasts exactly 2^ADDR_WIDTH cycles after reset deassertion; o_INIT_DONE and o_REQ_READY rise together in the following cycle.

## Configuration
- BRAM_ACCESS_CTRL_CLEAR_EN defined: CLEAR state, clr_addr counter and zero-fill present; o_INIT_DONE low during fill.
- Undefined: no CLEAR state; RUN directly after reset; o_INIT_DONE tied 1; memory contents untouched.

## Test plan
- CLEAR_EN, ADDR_WIDTH=4: release reset -> 16 cycles of write enable addr 0..15 data 0x00, o_INIT_DONE high on cycle 17; then read addr 0x7 -> 0x00.
- Write addr 0xD data 0x46, next cycle read 0xD -> o_RSP_VALID next cycle, data 0x46.
- Back-to-back reads 0x1,0x2,0x3 (preloaded 0x11,0x22,0x33), i_RSP_READY=1 -> responses 0x11,0x22,0x33 on consecutive cycles, ready never drops.
- i_RSP_READY=0, reads 0x1,0x2,0x3 offered -> two accepted, third held with o_REQ_READY=0; raise i_RSP_READY -> 0x11,0x22 out in order, then third accepted, 0x33 returned.
- During backpressure, write 0xF data 0x87 -> accepted immediately while reads stalled.
- Assert i_RST_N=0 mid-burst with 2 buffered responses -> o_RSP_VALID=0 immediately, FIFO empty after release, CLEAR restarts at 0.

Source files
------------

// File: rtl/bram_access_ctrl.sv
// ---------------------------------------------------------------------------
// bram_access_ctrl
//   Client-side access controller for one port pair of dual_port_bram.
//   Converts a valid/ready request stream into per-cycle BRAM strobes and
//   returns read data on a valid/ready response channel. The BRAM's one-cycle
//   read latency is absorbed by a bypass path plus a 2-entry response FIFO,
//   so reads are returned in order and held under response backpressure.
//
//   Optional build macro: BRAM_ACCESS_CTRL_CLEAR_EN
//     defined   : zero-fill of every address after reset (CLEAR state), then RUN
//     undefined : RUN directly after reset, memory contents untouched
//
// Ports
//   i_CLK, i_RST_N                 clock, async active-low reset
//   i_REQ_VALID/o_REQ_READY        request handshake
//   i_REQ_WRITE/ADDRESS/DATA       request payload (1 = write, 0 = read)
//   o_RSP_VALID/i_RSP_READY        read response handshake
//   o_RSP_DATA                     read response data
//   o_MEM_WRITE_*                  BRAM write port strobes
//   o_MEM_READ_ENABLE/ADDRESS      BRAM read port strobes
//   i_MEM_READ_DATA                BRAM registered read data
//   o_INIT_DONE                    controller is in RUN
// ---------------------------------------------------------------------------
module bram_access_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RST_N,
  input  logic                  i_REQ_VALID,
  output logic                  o_REQ_READY,
  input  logic                  i_REQ_WRITE,
  input  logic [ADDR_WIDTH-1:0] i_REQ_ADDRESS,
  input  logic [DATA_WIDTH-1:0] i_REQ_DATA,
  output logic                  o_RSP_VALID,
  input  logic                  i_RSP_READY,
  output logic [DATA_WIDTH-1:0] o_RSP_DATA,
  output logic                  o_MEM_WRITE_ENABLE,
  output logic [ADDR_WIDTH-1:0] o_MEM_WRITE_ADDRESS,
  output logic [DATA_WIDTH-1:0] o_MEM_WRITE_DATA,
  output logic                  o_MEM_READ_ENABLE,
  output logic [ADDR_WIDTH-1:0] o_MEM_READ_ADDRESS,
  input  logic [DATA_WIDTH-1:0] i_MEM_READ_DATA,
  output logic                  o_INIT_DONE
);

  logic                  w_clear;    // zero-fill strobes active this cycle
  logic                  w_run;      // requests may be accepted this cycle
  logic [ADDR_WIDTH-1:0] w_clr_addr;

`ifdef BRAM_ACCESS_CTRL_CLEAR_EN
  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;
  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_addr;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_CLEAR && r_clr_addr == '1) w_state_nxt = S_RUN;
  end

  // Gated by the reset pin so no strobe escapes while reset is held.
  assign w_clear     = (r_state == S_CLEAR) & i_RST_N;
  assign w_run       = (r_state == S_RUN) & i_RST_N;
  assign w_clr_addr  = r_clr_addr;
  assign o_INIT_DONE = (r_state == S_RUN);
`else
  assign w_clear     = 1'b0;
  assign w_run       = i_RST_N;
  assign w_clr_addr  = '0;
  assign o_INIT_DONE = 1'b1;
`endif

  // ---------------- request acceptance ----------------
  logic                  r_rd_inflight;
  logic [1:0]            r_count;
  logic                  r_wr_ptr, r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_fifo [2];
  logic [1:0]            w_occ;
  logic                  w_acc, w_wr_acc, w_rd_acc;
  logic                  w_fifo_ne, w_push, w_pop;

  // Occupancy counts every read that still owes a response slot; a read is
  // admitted only when a FIFO slot is guaranteed for its data.
  assign w_occ       = {1'b0, r_rd_inflight} + r_count;
  assign o_REQ_READY = w_run & (i_REQ_WRITE | (w_occ < 2'd2));
  assign w_acc       = i_REQ_VALID & o_REQ_READY;
  assign w_wr_acc    = w_acc & i_REQ_WRITE;
  assign w_rd_acc    = w_acc & ~i_REQ_WRITE;

  always_comb begin
    o_MEM_WRITE_ENABLE  = 1'b0;
    o_MEM_WRITE_ADDRESS = '0;
    o_MEM_WRITE_DATA    = '0;
    o_MEM_READ_ENABLE   = 1'b0;
    o_MEM_READ_ADDRESS  = '0;
    if (w_clear) begin
      o_MEM_WRITE_ENABLE  = 1'b1;
      o_MEM_WRITE_ADDRESS = w_clr_addr;
    end else if (w_wr_acc) begin
      o_MEM_WRITE_ENABLE  = 1'b1;
      o_MEM_WRITE_ADDRESS = i_REQ_ADDRESS;
      o_MEM_WRITE_DATA    = i_REQ_DATA;
    end
    if (w_rd_acc) begin
      o_MEM_READ_ENABLE  = 1'b1;
      o_MEM_READ_ADDRESS = i_REQ_ADDRESS;
    end
  end

  // ---------------- response path ----------------
  assign w_fifo_ne   = (r_count != 2'd0);
  assign o_RSP_VALID = w_fifo_ne | r_rd_inflight;
  // Older buffered data goes first; fresh BRAM data bypasses only when empty.
  assign o_RSP_DATA  = w_fifo_ne     ? r_fifo[r_rd_ptr] :
                       r_rd_inflight ? i_MEM_READ_DATA  : '0;
  assign w_pop       = w_fifo_ne & i_RSP_READY;
  // Arriving data is buffered unless the bypass hands it out this cycle.
  assign w_push      = r_rd_inflight & ~(~w_fifo_ne & i_RSP_READY);

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_rd_inflight <= 1'b0;
      r_count       <= 2'd0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
    end else begin
      r_rd_inflight <= w_rd_acc;
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge i_CLK) begin
    if (w_push) r_fifo[r_wr_ptr] <= i_MEM_READ_DATA;
  end

endmodule
